// File: rtl/hash_msg_streamer.sv
// hash_msg_streamer: buffers host message words, feeds them to the Hash core and captures its digest words
module hash_msg_streamer #(
    parameter int DEPTH   = 32,
    parameter int AW      = 5,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [63:0] wr_data,
    input  logic        go,
    input  logic [2:0]  go_mode,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        buf_full,
    output logic [6:0]  res_count,
    input  logic [5:0]  rd_addr,
    output logic [47:0] rd_data,
    output logic        h_start_calc,
    output logic [2:0]  h_mode,
    output logic [63:0] h_in,
    output logic        h_in_valid,
    output logic        h_is_last,
    input  logic        h_ack,
    input  logic [47:0] h_out,
    input  logic        h_ready,
    input  logic [5:0]  h_addr,
    input  logic        h_finish
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, START, SEND, GAP, COLLECT, DONE, ERR} state_t;

    state_t        state, state_nx;
    logic [63:0]   buffer [DEPTH];
    logic [47:0]   result [64];
    logic [AW:0]   count, rd_ptr;
    logic [TW-1:0] tmo;
    logic          err_q, last, tmo_hit, wr_ok;

    assign last     = rd_ptr == count - (AW+1)'(1);
    assign tmo_hit  = tmo == TW'(TIMEOUT - 1);
    assign buf_full = count == (AW+1)'(DEPTH);
    assign wr_ok    = state == IDLE && wr_en && !buf_full;
    assign busy     = state != IDLE;
    assign done     = state == DONE;
    assign err      = err_q || state == ERR;
    assign rd_data  = result[rd_addr];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and core-side handshake outputs
    always_comb begin
        state_nx     = state;
        h_start_calc = 1'b0;
        h_in_valid   = 1'b0;
        h_is_last    = 1'b0;
        h_in         = '0;
        case (state)
            IDLE:    state_nx = (go && count != '0) ? START : IDLE;
            START: begin
                h_start_calc = 1'b1;
                state_nx     = SEND;
            end
            SEND: begin
                h_in_valid = 1'b1;
                h_in       = buffer[rd_ptr[AW-1:0]];
                h_is_last  = last;
                state_nx   = h_ack ? (last ? COLLECT : GAP) : (tmo_hit ? ERR : SEND);
            end
            GAP:     state_nx = SEND;
            COLLECT: state_nx = h_ready ? (h_finish ? DONE : COLLECT) : (tmo_hit ? ERR : COLLECT);
            default: state_nx = IDLE;
        endcase
    end

    // Counters, pointers, latched mode and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            rd_ptr    <= '0;
            res_count <= '0;
            tmo       <= '0;
            err_q     <= 1'b0;
            h_mode    <= '0;
        end else begin
            tmo <= ((state == SEND && !h_ack) || (state == COLLECT && !h_ready)) ? tmo + TW'(1) : '0;
            case (state)
                IDLE: begin
                    if (wr_ok) count <= count + (AW+1)'(1);
                    if (go && count == '0) err_q <= 1'b1;
                    if (go && count != '0) begin
                        h_mode    <= go_mode;
                        err_q     <= 1'b0;
                        res_count <= '0;
                        rd_ptr    <= '0;
                    end
                end
                SEND:    if (h_ack) rd_ptr <= rd_ptr + (AW+1)'(1);
                COLLECT: if (h_ready) res_count <= (res_count == 7'd64) ? res_count : res_count + 7'd1;
                DONE:    count <= '0;
                ERR: begin
                    count <= '0;
                    err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Message buffer and result file storage (not reset)
    always_ff @(posedge clk) begin
        if (wr_ok) buffer[count[AW-1:0]] <= wr_data;
        if (state == COLLECT && h_ready) result[h_addr] <= h_out;
    end
endmodule

// File: tb/tb_hash_msg_streamer.sv
// tb_hash_msg_streamer: directed checks of the host buffer, core handshake, digest capture and timeout
module tb_hash_msg_streamer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [63:0] wr_data = '0;
    logic        go = 1'b0;
    logic [2:0]  go_mode = '0;
    logic        busy, done, err, buf_full;
    logic [6:0]  res_count;
    logic [5:0]  rd_addr = '0;
    logic [47:0] rd_data;
    logic        h_start_calc;
    logic [2:0]  h_mode;
    logic [63:0] h_in;
    logic        h_in_valid, h_is_last;
    logic        h_ack = 1'b0;
    logic [47:0] h_out = '0;
    logic        h_ready = 1'b0;
    logic [5:0]  h_addr = '0;
    logic        h_finish = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int starts = 0;
    int hold;

    hash_msg_streamer dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .go(go), .go_mode(go_mode),
        .busy(busy), .done(done), .err(err), .buf_full(buf_full), .res_count(res_count),
        .rd_addr(rd_addr), .rd_data(rd_data), .h_start_calc(h_start_calc), .h_mode(h_mode),
        .h_in(h_in), .h_in_valid(h_in_valid), .h_is_last(h_is_last), .h_ack(h_ack),
        .h_out(h_out), .h_ready(h_ready), .h_addr(h_addr), .h_finish(h_finish)
    );

    always #5 clk = ~clk;

    // Tally of start pulses seen by the core
    always @(posedge clk) if (h_start_calc) starts <= starts + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [63:0] d);
        wr_en = 1'b1;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic go_cmd(input logic [2:0] m);
        go = 1'b1;
        go_mode = m;
        tick();
        go = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] d, input logic l);
        for (int c = 0; c < 4; c++) begin
            check("in_valid", h_in_valid, 1);
            check("in_data", h_in, d);
            check("is_last", h_is_last, l);
            check("no_start", h_start_calc, 0);
            if (c < 3) tick();
        end
        h_ack = 1'b1;
        tick();
        h_ack = 1'b0;
        if (!l) begin
            check("gap_valid", h_in_valid, 0);
            check("gap_last", h_is_last, 0);
            tick();
        end
    endtask

    task automatic collect(input int n, input int first, input logic [47:0] base);
        check("wait_busy", busy, 1);
        check("wait_done", done, 0);
        check("wait_valid", h_in_valid, 0);
        tick();
        for (int a = 0; a < n; a++) begin
            h_ready = 1'b1;
            h_addr = 6'(first + a);
            h_out = base + 48'(a);
            h_finish = (a == n - 1);
            tick();
        end
        h_ready = 1'b0;
        h_finish = 1'b0;
        check("done_pulse", done, 1);
        check("res_count", res_count, 64'(n));
        tick();
        check("done_low", done, 0);
        check("busy_low", busy, 0);
        check("buf_empty", buf_full, 0);
    endtask

    initial begin
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_full", buf_full, 0);
        check("rst_rescnt", res_count, 0);
        check("rst_start", h_start_calc, 0);
        check("rst_mode", h_mode, 0);
        check("rst_valid", h_in_valid, 0);
        check("rst_last", h_is_last, 0);
        check("rst_in", h_in, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // six-word run, mode 1
        for (int i = 1; i <= 6; i++) write_word(64'hC0DE_0000_0000_0000 + 64'(i));
        check("t1_notfull", buf_full, 0);
        check("t1_idle", busy, 0);
        go_cmd(3'd1);
        check("t1_start", h_start_calc, 1);
        check("t1_busy", busy, 1);
        check("t1_mode", h_mode, 1);
        check("t1_noerr", err, 0);
        tick();
        for (int i = 1; i <= 6; i++) send_word(64'hC0DE_0000_0000_0000 + 64'(i), i == 6);
        collect(4, 0, 48'hA0);
        rd_addr = 6'd2;
        #1 check("t1_rd2", rd_data, 48'hA2);
        rd_addr = 6'd3;
        #1 check("t1_rd3", rd_data, 48'hA3);
        check("t1_starts", 64'(starts), 1);

        // go with empty buffer
        go_cmd(3'd5);
        check("t3_err", err, 1);
        check("t3_busy", busy, 0);
        check("t3_start", h_start_calc, 0);
        repeat (3) tick();
        check("t3_busy2", busy, 0);
        check("t3_starts", 64'(starts), 1);

        // ack withheld on word 2 until the timeout fires
        for (int i = 0; i < 3; i++) write_word(64'h7700 + 64'(i));
        go_cmd(3'd2);
        check("t4_errclr", err, 0);
        check("t4_mode", h_mode, 2);
        tick();
        send_word(64'h7700, 0);
        hold = 0;
        while (h_in_valid && hold < 2000) begin
            hold++;
            tick();
        end
        check("t4_hold", 64'(hold), 1024);
        check("t4_valid", h_in_valid, 0);
        check("t4_err", err, 1);
        tick();
        check("t4_idle", busy, 0);
        check("t4_errstk", err, 1);
        write_word(64'h5A5A_0001);
        write_word(64'h5A5A_0002);
        go_cmd(3'd4);
        check("t4_errclr2", err, 0);
        tick();
        send_word(64'h5A5A_0001, 0);
        send_word(64'h5A5A_0002, 1);
        collect(1, 5, 48'hBEEF);
        check("t4_noerr", err, 0);
        rd_addr = 6'd5;
        #1 check("t4_rd5", rd_data, 48'hBEEF);

        // overfill: 33rd word dropped
        for (int i = 0; i < 31; i++) write_word(64'hF000 + 64'(i));
        check("t5_31full", buf_full, 0);
        write_word(64'hF000 + 64'd31);
        check("t5_full", buf_full, 1);
        write_word(64'hDEAD);
        check("t5_noerr", err, 0);
        go_cmd(3'd6);
        tick();
        for (int i = 0; i < 32; i++) send_word(64'hF000 + 64'(i), i == 31);
        collect(2, 10, 48'h123);
        check("t5_starts", 64'(starts), 4);

        // reset mid-SEND then a single-word run
        write_word(64'h1);
        write_word(64'h2);
        go_cmd(3'd7);
        tick();
        check("t6_insend", h_in_valid, 1);
        rst_n = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_valid", h_in_valid, 0);
        check("t6_in", h_in, 0);
        check("t6_mode", h_mode, 0);
        check("t6_rescnt", res_count, 0);
        check("t6_full", buf_full, 0);
        #3 rst_n = 1'b1;
        tick();
        write_word(64'h0123_4567_89AB_CDEF);
        go_cmd(3'd3);
        check("t6_start", h_start_calc, 1);
        check("t6_mode3", h_mode, 3);
        tick();
        send_word(64'h0123_4567_89AB_CDEF, 1);
        collect(1, 63, 48'hCAFE_F00D);
        rd_addr = 6'd63;
        #1 check("t6_rd63", rd_data, 48'hCAFE_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hash_msg_streamer.md
Name: hash_msg_streamer

Overview:
Initiator that drives the message/control side of the Hash core: buffers 64-bit message words from a host, issues start_calc with a mode, and streams words over the in/in_valid/is_last/ack handshake. After the last word it collects the 48-bit digest words presented on out/addr while ready is high, until finish. Sits between host logic and Hash; the host reads results from an internal result file.

Parameters:
DEPTH, 32, message buffer depth in 64-bit words (power of 2)
AW, 5, log2(DEPTH)
TIMEOUT, 1024, max cycles waiting for h_ack or for h_ready/h_finish before error

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  host write of one message word (ignored unless IDLE and not full)
wr_data  in  64  message word
go  in  1  start hashing the buffered words (sampled in IDLE only)
go_mode  in  3  mode forwarded to core
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on successful completion
err  out  1  sticky error; cleared by next accepted go
buf_full  out  1  word count == DEPTH
res_count  out  7  digest words captured in last run
rd_addr  in  6  result file read address
rd_data  out  48  result word, combinational from rd_addr
h_start_calc  out  1  start pulse to core
h_mode  out  3  latched mode
h_in  out  64  message word to core
h_in_valid  out  1  word valid
h_is_last  out  1  marks final message word
h_ack  in  1  core accepted current word
h_out  in  48  digest word
h_ready  in  1  h_out/h_addr valid this cycle
h_addr  in  6  index of h_out
h_finish  in  1  current digest word is the last

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; wr count, rd pointer, res_count, timeout counter 0. Result file contents not reset.
- IDLE: wr_en && !buf_full writes buffer[count], count++; wr_en when full dropped, no error. go with count==0: err=1, stay IDLE, no h_start_calc. go with count>0: latch go_mode into h_mode, clear err, res_count=0, rd_ptr=0 -> START.
- START: h_start_calc=1 for exactly one cycle -> SEND.
- SEND: h_in_valid=1, h_in=buffer[rd_ptr], h_is_last=(rd_ptr==count-1). Held stable until h_ack sampled 1. On ack: rd_ptr++; last word -> WAIT_READY, else -> GAP. h_ack while h_in_valid=0 ignored.
- GAP: h_in_valid=0, h_is_last=0 for exactly one cycle -> SEND. Latency go -> first h_in_valid: 2 cycles.
- WAIT_READY/COLLECT: each cycle h_ready=1: result[h_addr]=h_out, res_count++; if h_finish also 1 -> DONE. Timeout counter resets on each capture.
- DONE: done=1 one cycle, count=0 (buffer emptied) -> IDLE.
- Timeout: counter counts cycles in SEND and WAIT_READY without progress; reaching TIMEOUT -> ERR: h_in_valid=0, err=1, count=0 -> IDLE next cycle. err stays high until next accepted go.
- h_ack and h_ready same cycle: only the one relevant to current state acted on.
- res_count saturates at 64; h_addr writes wrap naturally within 64 entries.

Test Plan:
- Write 6 words 0x...01..0x...06, go mode=1, core acks 3 cycles after each valid -> one h_start_calc pulse, 6 transfers in order, h_is_last only on word 6, h_in_valid low exactly 1 cycle between words.
- After last ack, core drives h_ready with addr 0..3, h_out=0xA0..0xA3, h_finish on addr 3 -> res_count=4, rd_data(2)=0xA2, done one pulse, busy falls.
- go with empty buffer -> err=1, h_start_calc never asserted, busy stays 0.
- Core withholds h_ack for TIMEOUT cycles on word 2 -> err=1, h_in_valid=0, IDLE; next go with new words clears err and completes.
- Write 33 words (DEPTH=32) -> buf_full after 32nd, 33rd dropped, exactly 32 words sent, last flagged.
- rst_n low mid-SEND -> all outputs 0 immediately; after release, refill 1 word and go -> normal single-word run with h_is_last=1.
